// File: rtl/rca_acc_32.sv
// Streaming accumulator built around a ripple-carry adder. It sums a frame of beats and then holds the total, carry count and beat count on a valid/ready port.
// Optional macro RCA_ACC_SAT_EN: the accumulator clamps to all-ones on carry-out instead of wrapping.

module rca_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic carry;

  // Explicit bit-serial carry chain, so the adder stays a true ripple-carry structure.
  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module rca_acc_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] carries_q, carries_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_carries_q, out_carries_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] beats_inc, carries_inc;

  rca_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (in_cin),
    .s    (sum),
    .cout (cout)
  );

  always_comb begin
    beats_inc   = (beats_q == {CNT_W{1'b1}}) ? beats_q : beats_q + 1'b1;
    carries_inc = carries_q;
    if (cout && (carries_q != {CNT_W{1'b1}})) begin
      carries_inc = carries_q + 1'b1;
    end
`ifdef RCA_ACC_SAT_EN
    // A lost carry pins the total at all-ones for the rest of the frame.
    acc_next = (cout || (acc_q == {WIDTH{1'b1}})) ? {WIDTH{1'b1}} : sum;
`else
    acc_next = sum;
`endif
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    beats_d       = beats_q;
    carries_d     = carries_q;
    out_sum_d     = out_sum_q;
    out_carries_d = out_carries_q;
    out_beats_d   = out_beats_q;

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d     = acc_next;
          beats_d   = beats_inc;
          carries_d = carries_inc;
          if (in_last) begin
            out_sum_d     = acc_next;
            out_carries_d = carries_inc;
            out_beats_d   = beats_inc;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        // Input beats are ignored here, so no beat can share the handshake cycle.
        if (out_ready) begin
          acc_d     = '0;
          beats_d   = '0;
          carries_d = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      acc_q         <= '0;
      beats_q       <= '0;
      carries_q     <= '0;
      out_sum_q     <= '0;
      out_carries_q <= '0;
      out_beats_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      beats_q       <= beats_d;
      carries_q     <= carries_d;
      out_sum_q     <= out_sum_d;
      out_carries_q <= out_carries_d;
      out_beats_q   <= out_beats_d;
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign out_sum     = out_sum_q;
  assign out_carries = out_carries_q;
  assign out_beats   = out_beats_q;

endmodule

// File: tb/tb_rca_acc_32.sv
// Self-checking bench for rca_acc_32: a frame-level arithmetic model checked every cycle, plus directed frames with hand-computed results.
// Honours RCA_ACC_SAT_EN when the design is built with it.

module tb_rca_acc_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_cin = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [7:0]  out_carries;
  logic [7:0]  out_beats;

  int checks = 0;
  int errors = 0;

  rca_acc_32 #(.WIDTH(32), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_cin      (in_cin),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_beats   (out_beats)
  );

  always #5 clk = ~clk;

  // Frame-level model: plain wide arithmetic, counters clamped with min().
  logic [31:0] m_total, m_out_sum;
  int          m_beats, m_carries, m_out_beats, m_out_carries;
  bit          m_hold;

  always @(posedge clk or posedge rst) begin
    longint unsigned t;
    logic [31:0]     nt;
    int              nb, nc;
    if (rst) begin
      m_total <= '0; m_beats <= 0; m_carries <= 0; m_hold <= 1'b0;
      m_out_sum <= '0; m_out_beats <= 0; m_out_carries <= 0;
    end else if (!m_hold && in_valid) begin
      t  = longint'(m_total) + longint'(in_data) + longint'(in_cin);
      nt = t[31:0];
      nc = m_carries;
      if (t >= 64'h1_0000_0000) begin
        nc = (m_carries + 1 > 255) ? 255 : m_carries + 1;
`ifdef RCA_ACC_SAT_EN
        nt = 32'hFFFF_FFFF;
`endif
      end
`ifdef RCA_ACC_SAT_EN
      if (m_total == 32'hFFFF_FFFF) nt = 32'hFFFF_FFFF;
`endif
      nb = (m_beats + 1 > 255) ? 255 : m_beats + 1;
      m_total   <= nt;
      m_beats   <= nb;
      m_carries <= nc;
      if (in_last) begin
        m_hold        <= 1'b1;
        m_out_sum     <= nt;
        m_out_beats   <= nb;
        m_out_carries <= nc;
      end
    end else if (m_hold && out_ready) begin
      m_hold <= 1'b0; m_total <= '0; m_beats <= 0; m_carries <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("cyc_in_ready", {63'd0, in_ready}, {63'd0, !m_hold});
    checkOutput("cyc_out_valid", {63'd0, out_valid}, {63'd0, m_hold});
    checkOutput("cyc_out_sum", {32'd0, out_sum}, {32'd0, m_out_sum});
    checkOutput("cyc_out_carries", {56'd0, out_carries}, 64'(m_out_carries));
    checkOutput("cyc_out_beats", {56'd0, out_beats}, 64'(m_out_beats));
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic c,
                               input logic last, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_cin    = c;
    in_last   = last;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string name, input logic [31:0] s, input int c, input int b);
    checkOutput({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({name, "_ready"}, {63'd0, in_ready}, 64'd0);
    checkOutput({name, "_sum"}, {32'd0, out_sum}, {32'd0, s});
    checkOutput({name, "_carries"}, {56'd0, out_carries}, 64'(c));
    checkOutput({name, "_beats"}, {56'd0, out_beats}, 64'(b));
  endtask

  task automatic doHandshake(input string name);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput({name, "_hs_ready"}, {63'd0, in_ready}, 64'd1);
    checkOutput({name, "_hs_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] exp_wrap, exp_csat;
`ifdef RCA_ACC_SAT_EN
    exp_wrap = 32'hFFFF_FFFF;
    exp_csat = 32'hFFFF_FFFF;
`else
    exp_wrap = 32'h0000_0001;
    exp_csat = 32'hFFFF_FEFC;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_sum", {32'd0, out_sum}, 64'd0);
    checkOutput("rst_out_beats", {56'd0, out_beats}, 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] three-beat frame");
    applyStimulus(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd30, 1'b0, 1'b1, 1'b0);
    checkResult("three", 32'd60, 0, 3);
    doHandshake("three");

    $display("[TB] wrap frame");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
    checkResult("wrap", exp_wrap, 1, 2);
    doHandshake("wrap");

    $display("[TB] single beat with carry-in");
    applyStimulus(1'b1, 32'd7, 1'b1, 1'b1, 1'b0);
    checkResult("single", 32'd8, 0, 1);
    doHandshake("single");

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
      checkResult("bp_hold", 32'h100, 0, 1);
    end
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_hs_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("bp_hs_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("bp_hs_sum_kept", {32'd0, out_sum}, 64'h100);
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b1, 1'b0);
    checkResult("bp_next", 32'd4, 0, 1);
    doHandshake("bp_next");

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("mid_rst_sum", {32'd0, out_sum}, 64'd0);
    checkOutput("mid_rst_beats", {56'd0, out_beats}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'd9, 1'b0, 1'b1, 1'b0);
    checkResult("after_rst", 32'd9, 0, 1);
    doHandshake("after_rst");

    $display("[TB] beat counter saturation");
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b1, 32'd1, 1'b0, (i == 300), 1'b0);
    end
    checkResult("beat_sat", 32'd300, 0, 255);
    doHandshake("beat_sat");

    $display("[TB] carry counter saturation");
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, (i == 260), 1'b0);
    end
    checkResult("carry_sat", exp_csat, 255, 255);
    doHandshake("carry_sat");

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
